// File: rtl/memory_if_pkg.sv
// Shared constants and state encoding for the burst memory reader/writer pair.
package memory_if_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_WORDS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/memory_write.sv
// Burst memory writer: captures one line plus base address, then writes it
// out as consecutive words, holding each word while the memory is stalled.
module memory_write
  import memory_if_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int WORDS  = MEM_WORDS
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [ADDR_W-1:0]        AddrIn,
  input  logic [DATA_W*WORDS-1:0]  DataIn,
  input  logic                     MemBusy,
  output logic [ADDR_W-1:0]        Addr,
  output logic [DATA_W-1:0]        MemData,
  output logic                     WR,
  output logic                     Busy,
  output logic                     done_vld
);

  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LINE_W = DATA_W * WORDS;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORDS - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state logic; outputs are precomputed for the upcoming cycle so every
  // port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    line_d  = line_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          base_d  = AddrIn;
          line_d  = DataIn;
          wr_d    = 1'b1;
          addr_d  = AddrIn;
          data_d  = DataIn[DATA_W-1:0];
        end
      end
      ST_WRITE: begin
        wr_d = 1'b1;
        if (!MemBusy) begin
          if (cnt_q == LAST_K) begin
            state_d = ST_DONE;
            wr_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_inc;
            addr_d = base_q + ADDR_W'(cnt_inc);
            data_d = line_q[cnt_inc*DATA_W +: DATA_W];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers; reset aborts any burst in flight at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Line buffer is plain data storage, so it is left out of reset.
  always_ff @(posedge Clk) begin
    line_q <= line_d;
  end

  assign Addr     = addr_q;
  assign MemData  = data_q;
  assign WR       = wr_q;
  assign Busy     = busy_q;
  assign done_vld = done_q;

endmodule

// File: doc/memory_write.md
# memory_write

Burst memory writer, the write-side counterpart of the 16-word burst reader. It accepts a 256-bit line plus base address in one handshake and writes it to the 16-bit memory as 16 consecutive word writes, honouring memory back-pressure. It completes with a one-cycle `done_vld` pulse. It sits between the datapath (line producer) and the shared memory port.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory word width.
- `WORDS`, default 16: words per burst. `DATA_W*WORDS` is the line width, 256 by default.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: reset. Asynchronous and active-high.
- `Start`, in, 1: burst request. Sampled only while `Busy`=0.
- `AddrIn`, in, `ADDR_W`: base address. Captured when `Start` is accepted.
- `DataIn`, in, `DATA_W*WORDS`: line to write. Captured when `Start` is accepted. Word k is `DataIn[16k+15:16k]`.
- `MemBusy`, in, 1: memory stall. A write is accepted on an edge where `WR`=1 and `MemBusy`=0.
- `Addr`, out, `ADDR_W`: memory address.
- `MemData`, out, `DATA_W`: write data.
- `WR`, out, 1: write strobe.
- `Busy`, out, 1: burst in progress. High in WRITE and DONE.
- `done_vld`, out, 1: one-cycle pulse after the last word is accepted.

## Operation
- **States:** IDLE, WRITE, DONE.
- **IDLE:**
  - `WR`=0 and `Busy`=0.
  - When `Start`=1 at an edge: latch `AddrIn` into the base register and `DataIn` into the line buffer, clear the word counter, and go to WRITE.
  - After capture, changes on `AddrIn` and `DataIn` have no effect on the burst.
- **WRITE:**
  - Outputs are driven from the current counter value k: `WR`=1, `Addr`=base+k (mod 2^`ADDR_W`), `MemData`=word k of the line buffer.
  - If `MemBusy`=0 at an edge, word k is accepted. If k<`WORDS`-1, k increments; if k=`WORDS`-1, go to DONE.
  - If `MemBusy`=1, state, k, `Addr`, `MemData` and `WR` all hold.
- **DONE:** `done_vld`=1, `WR`=0, `Busy`=1. Go to IDLE on the next edge unconditionally.
- **Start while busy:** `Start` is ignored in WRITE and DONE. It is not queued.
- **Address arithmetic:** modulo 2^`ADDR_W`. A base of 0xFFF8 wraps to 0x0000 at k=8.
- **Counter:** width is clog2(`WORDS`). It never exceeds `WORDS`-1.
- **Reset:** asserting `Rst` at any time, including mid-burst, forces these values immediately without waiting for a clock edge:
  - state=IDLE, `WR`=0, `Busy`=0, `done_vld`=0, `Addr`=0, `MemData`=0, counter=0.
  - The aborted burst is not resumed.
  - The line buffer may be left unreset.

## Timing
- `Start` accepted at edge E0. First write presented (`WR`=1, `Addr`=base, word 0) in the cycle following E0.
- With no stalls, words 0..15 occupy 16 consecutive cycles.
- `done_vld` is high in cycle 17 after E0. IDLE is re-entered at the following edge.
- Earliest next `Start` accept is at the edge ending the DONE cycle plus one, i.e. 18 cycles between accepts.
- Each stall cycle adds exactly one cycle of latency. The word under stall is written once.
- `WR` never deasserts between words of an unstalled burst.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package `memory_if_pkg` holds:
  - `ADDR_W`, `DATA_W` and `WORDS` constants.
  - The state typedef (IDLE/WRITE/DONE).
  - Reader and writer both import it.
- Flat module. The line buffer plus word select is simple enough that no sub-module is warranted.

## Test plan
- **Single burst, no stall:** base 0x0100, line words = 0x1000+k. Expect 16 writes with `Addr`=0x0100..0x010F and `MemData`=0x1000..0x100F, then `done_vld` in cycle 17.
- **Stall:** hold `MemBusy`=1 for 3 cycles while word 5 is presented. Expect `Addr`=0x0105 / `MemData`=0x1005 held for 4 cycles, word 5 written once, `done_vld` in cycle 20.
- **Address wrap:** base 0xFFF8. Expect `Addr` sequence 0xFFF8..0xFFFF, 0x0000..0x0007.
- **Start during busy, input change after capture:** pulse `Start` at word 7 with base 0x2000, and change `DataIn` after the accept. Expect no effect on the active burst, the original data written, and no second burst.
- **Reset mid-burst:** assert `Rst` at word 9 between clock edges. Expect `WR`/`Busy`=0 immediately. After release, `Start` with base 0x0300 runs a full fresh 16-word burst from k=0.
- **Back-to-back:** reassert `Start` in the cycle after `done_vld`. Expect it accepted and a second burst starting 18 cycles after the first accept.
